// File: rtl/ram_mfc_ctrl.sv
// rtl/ram_mfc_ctrl.sv - word RAM with fixed-latency CPU access handshake (mfc) and priority loader write port
module ram_mfc_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 512,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    ovr_valid,
    input  logic [ADDR_WIDTH-1:0]   ovr_address,
    input  logic [DATA_WIDTH-1:0]   ovr_data,
    output logic                    ovr_ready,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    mfc,
    output logic                    busy,
    output logic                    err
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]       CNT_INIT = CW'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [NB-1:0]         r_be;
    logic                  r_is_write;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_mfc;
    logic                  r_err;

    // Zero-initialised storage; deliberately outside the reset domain so reset never disturbs contents.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

    logic          w_idle;
    logic          w_ovr_fire;
    logic          w_ovr_in_range;
    logic          w_cpu_in_range;
    logic          w_access;
    logic [IW-1:0] w_cpu_idx;
    logic [IW-1:0] w_ovr_idx;

    assign w_idle         = (r_state == S_IDLE);
    assign w_ovr_fire     = w_idle && ovr_valid;
    assign w_ovr_in_range = ({1'b0, ovr_address} < DEPTH_L);
    assign w_cpu_in_range = ({1'b0, r_addr} < DEPTH_L);
    assign w_access       = (r_state == S_WAIT) && (r_cnt == '0);
    assign w_cpu_idx      = r_addr[IW-1:0];
    assign w_ovr_idx      = ovr_address[IW-1:0];

    assign ovr_ready = w_idle;
    assign busy      = !w_idle;
    assign data_out  = r_dout;
    assign mfc       = r_mfc;
    assign err       = r_err;

    // Loader and CPU writes are exclusive: the loader only fires in IDLE, the CPU only at the end of WAIT.
    always_ff @(posedge clk) begin
        if (w_ovr_fire && w_ovr_in_range) begin
            r_mem[w_ovr_idx] <= ovr_data;
        end else if (w_access && r_is_write && w_cpu_in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (r_be[i]) begin
                    r_mem[w_cpu_idx][8*i +: 8] <= r_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_be       <= '0;
            r_is_write <= 1'b0;
            r_dout     <= '0;
            r_mfc      <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_mfc <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ovr_valid) begin
                        r_err <= !w_ovr_in_range;
                    end else if (enable && read && write) begin
                        r_err <= 1'b1;
                    end else if (enable && (read ^ write)) begin
                        r_addr     <= address;
                        r_data     <= data_in;
                        r_be       <= byte_en;
                        r_is_write <= write;
                        r_cnt      <= CNT_INIT;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_mfc   <= 1'b1;
                        r_err   <= !w_cpu_in_range;
                        r_state <= S_DONE;
                        if (!r_is_write) begin
                            r_dout <= w_cpu_in_range ? r_mem[w_cpu_idx] : '0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
